// File: rtl/sram_port_pkg.sv
// Shared types and helpers for the SRAM port master and its response FIFO.
// rsp_t is the default 32-bit response record; other widths build their own.
package sram_port_pkg;

   localparam int RSP_DATA_W    = 32;
   localparam int DEF_RSP_DEPTH = 3;
   localparam int RSP_PTR_W     = $clog2(DEF_RSP_DEPTH);

   typedef struct packed {
      logic [RSP_DATA_W-1:0] rdata;
      logic                  err;
      logic                  we;
   } rsp_t;

   // True when addr falls in the window [base, base + (4 << aw)).
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          aw);
      return (addr >> (aw + 2)) == (base >> (aw + 2));
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response FIFO.
// The caller never pushes when full and never pops when empty.
module sram_rsp_fifo
   import sram_port_pkg::*;
#(
   parameter int  DEPTH = DEF_RSP_DEPTH,
   parameter type T     = rsp_t,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  T              wdata,
   input  logic          pop,
   output T              rdata,
   output logic [CW-1:0] count
);

   T mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage needs no reset: the head is only consumed while count != 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sram_port_master.sv
// Drives one OpenRAM-style RW port from a valid/ready byte-addressed request
// stream and returns in-order responses, two cycles after accept at the earliest.
module sram_port_master
   import sram_port_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter int          DATA_WIDTH = 32,
   parameter int          NUM_WMASKS = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RSP_DEPTH  = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [31:0]           i_req_addr,
   input  logic [NUM_WMASKS-1:0] i_req_be,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic                  o_rsp_we,
   output logic                  o_sram_csb,
   output logic                  o_sram_web,
   output logic [NUM_WMASKS-1:0] o_sram_wmask,
   output logic [ADDR_WIDTH-1:0] o_sram_addr,
   output logic [DATA_WIDTH-1:0] o_sram_din,
   input  logic [DATA_WIDTH-1:0] i_sram_dout,
   output logic                  o_busy
);

   localparam int CW = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
      logic                  we;
   } rsp_w_t;

   logic          in_win, accept, pop;
   logic          s1_valid, s1_we, s1_err, s1_rd;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occ;
   rsp_w_t        push_rsp, head;

   assign in_win = in_window(i_req_addr, BASE_ADDR, ADDR_WIDTH);
   assign pop    = o_rsp_valid & i_rsp_ready;

   // Slots already promised: the S1 entry plus buffered responses, less the
   // one leaving this cycle. pop implies fifo_count >= 1, so no underflow.
   assign occ         = (CW+1)'(s1_valid) + (CW+1)'(fifo_count) - (CW+1)'(pop);
   assign o_req_ready = i_reset_n & (occ < (CW+1)'(RSP_DEPTH));
   assign accept      = i_req_valid & o_req_ready;

   // web/wmask are qualified by accept so they idle inactive under reset.
   assign o_sram_csb   = !(accept & in_win);
   assign o_sram_web   = !(accept & i_req_we);
   assign o_sram_wmask = (accept & i_req_we) ? i_req_be : '0;
   assign o_sram_addr  = i_req_addr[ADDR_WIDTH+1:2];
   assign o_sram_din   = i_req_wdata;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_valid <= 1'b0;
         s1_we    <= 1'b0;
         s1_err   <= 1'b0;
         s1_rd    <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_we    <= i_req_we;
         s1_err   <= !in_win;
         s1_rd    <= accept & in_win & !i_req_we;
      end
   end

   // The macro's dout is valid during S1 only for the read it launched.
   assign push_rsp.rdata = s1_rd ? i_sram_dout : '0;
   assign push_rsp.err   = s1_err;
   assign push_rsp.we    = s1_we;

   sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_w_t)
   ) u_rsp_fifo (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .push  (s1_valid),
      .wdata (push_rsp),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count)
   );

   assign o_rsp_valid = (fifo_count != '0);
   assign o_rsp_rdata = o_rsp_valid ? head.rdata : '0;
   assign o_rsp_err   = o_rsp_valid & head.err;
   assign o_rsp_we    = o_rsp_valid & head.we;
   assign o_busy      = s1_valid | (fifo_count != '0);

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: SRAM macro model, request-level reference model
// with per-cycle comparison, directed scenarios and a randomized phase.
module tb_sram_port_master;

   localparam int          AW    = 12;
   localparam int          DW    = 32;
   localparam int          NW    = 4;
   localparam int          DEPTH = 3;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic          i_clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_req_valid = 1'b0, i_req_we = 1'b0, i_rsp_ready = 1'b1;
   logic [31:0]   i_req_addr = '0;
   logic [NW-1:0] i_req_be = '0;
   logic [DW-1:0] i_req_wdata = '0, i_sram_dout = '0;
   logic          o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_we, o_sram_csb, o_sram_web, o_busy;
   logic [DW-1:0] o_rsp_rdata, o_sram_din;
   logic [NW-1:0] o_sram_wmask;
   logic [AW-1:0] o_sram_addr;

   always #5 i_clk = ~i_clk;

   sram_port_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .BASE_ADDR(BASE), .RSP_DEPTH(DEPTH)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_be(i_req_be), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
      .o_rsp_err(o_rsp_err), .o_rsp_we(o_rsp_we),
      .o_sram_csb(o_sram_csb), .o_sram_web(o_sram_web), .o_sram_wmask(o_sram_wmask),
      .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din), .i_sram_dout(i_sram_dout),
      .o_busy(o_busy)
   );

   int checks = 0, fails = 0, cyc = 0, ready_drops = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // SRAM macro: inputs registered at posedge, dout valid the following cycle.
   logic [31:0] sram_mem [4096];
   logic [31:0] ref_mem  [4096];
   always @(posedge i_clk) begin
      if (!o_sram_csb) begin
         if (!o_sram_web) begin
            for (int b = 0; b < NW; b++)
               if (o_sram_wmask[b]) sram_mem[o_sram_addr][8*b +: 8] <= o_sram_din[8*b +: 8];
         end else begin
            i_sram_dout <= sram_mem[o_sram_addr];
         end
      end
   end

   // Reference model: every accepted request owes one response, in order,
   // no earlier than two cycles after its accept.
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        we;
      int          cyc;
   } ent_t;
   ent_t exp_q[$];
   ent_t got_q[$];
   int   acc_q[$];
   ent_t ce;
   logic        exp_valid, stall_prev = 1'b0, inw;
   logic [34:0] prev_rsp;
   logic [31:0] m;
   logic [11:0] widx;

   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         chk("rst_req_ready", o_req_ready, 0);
         chk("rst_rsp_valid", o_rsp_valid, 0);
         chk("rst_rsp_rdata", o_rsp_rdata, 0);
         chk("rst_rsp_err", o_rsp_err, 0);
         chk("rst_rsp_we", o_rsp_we, 0);
         chk("rst_csb", o_sram_csb, 1);
         chk("rst_web", o_sram_web, 1);
         chk("rst_wmask", o_sram_wmask, 0);
         chk("rst_busy", o_busy, 0);
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
         chk("rsp_valid", o_rsp_valid, exp_valid);
         if (exp_valid) begin
            chk("rsp_rdata", o_rsp_rdata, exp_q[0].rdata);
            chk("rsp_err", o_rsp_err, exp_q[0].err);
            chk("rsp_we", o_rsp_we, exp_q[0].we);
         end
         if (stall_prev)
            chk("stall_hold", {o_rsp_valid, o_rsp_err, o_rsp_we, o_rsp_rdata}, prev_rsp);
         chk("busy", o_busy, exp_q.size() != 0);
         chk("req_ready", o_req_ready,
             (exp_q.size() - ((exp_valid && i_rsp_ready) ? 1 : 0)) < DEPTH);
         if (exp_valid && i_rsp_ready) begin
            ce.rdata = o_rsp_rdata; ce.err = o_rsp_err; ce.we = o_rsp_we; ce.cyc = cyc;
            got_q.push_back(ce);
            void'(exp_q.pop_front());
         end
         stall_prev = o_rsp_valid & !i_rsp_ready;
         prev_rsp   = {o_rsp_valid, o_rsp_err, o_rsp_we, o_rsp_rdata};
         if (i_req_valid && !o_req_ready) ready_drops++;
         if (i_req_valid && o_req_ready) begin
            acc_q.push_back(cyc);
            inw  = (i_req_addr & 32'hFFFF_C000) == BASE;
            widx = i_req_addr[13:2];
            for (int b = 0; b < NW; b++) m[8*b +: 8] = {8{i_req_be[b]}};
            if (inw) begin
               chk("sram_csb", o_sram_csb, 0);
               chk("sram_web", o_sram_web, !i_req_we);
               chk("sram_addr", o_sram_addr, widx);
               chk("sram_din", o_sram_din, i_req_wdata);
               chk("sram_wmask", o_sram_wmask, i_req_we ? i_req_be : 4'b0);
            end else begin
               chk("sram_csb_oow", o_sram_csb, 1);
            end
            ce.we = i_req_we; ce.err = !inw; ce.cyc = cyc;
            ce.rdata = (inw && !i_req_we) ? ref_mem[widx] : 32'h0;
            if (inw && i_req_we) ref_mem[widx] = (ref_mem[widx] & ~m) | (i_req_wdata & m);
            exp_q.push_back(ce);
         end else begin
            chk("sram_csb_idle", o_sram_csb, 1);
         end
      end
   end

   task automatic send(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [11:0] sa,
                       output logic [3:0] sm, output logic scsb);
      int  n = 0;
      bit  done = 0;
      sa = '0; sm = '0; scsb = 1'b1;
      i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_be = be; i_req_wdata = wd;
      while (!done && n < 50) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            done = 1; sa = o_sram_addr; sm = o_sram_wmask; scsb = o_sram_csb;
         end
         n++;
      end
      if (!done) begin
         checks++; fails++;
         $display("FAIL send_timeout addr=%h no accept within 50 cycles", a);
      end
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge i_clk);
      while (o_busy && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      chk("idle_reached", o_busy, 0);
      @(posedge i_clk); #1;
   endtask

   logic [11:0] sa;
   logic [3:0]  sm;
   logic        scsb;
   int          c0, nacc;

   initial begin
      #2_000_000;
      checks++; fails++;
      $display("FAIL watchdog simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         sram_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
         ref_mem[i]  = sram_mem[i];
      end
      repeat (3) @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      @(posedge i_clk); #1;

      // Full write then read-back.
      got_q.delete();
      send(1, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, sa, sm, scsb);
      chk("t1_sram_addr", sa, 12'd1);
      chk("t1_sram_wmask", sm, 4'b1111);
      send(0, 32'h1000_0004, 4'b0000, 32'h0, sa, sm, scsb);
      wait_idle();
      chk("t1_nrsp", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("t1_ack_we", got_q[0].we, 1);
         chk("t1_ack_err", got_q[0].err, 0);
         chk("t1_rd_data", got_q[1].rdata, 32'hDEAD_BEEF);
      end

      // Partial byte write.
      got_q.delete();
      send(1, 32'h1000_0004, 4'b0100, 32'h00AA_0000, sa, sm, scsb);
      send(0, 32'h1000_0004, 4'b0000, 32'h0, sa, sm, scsb);
      wait_idle();
      if (got_q.size() >= 2) chk("t2_rd_data", got_q[1].rdata, 32'hDEAA_BEEF);
      else chk("t2_nrsp", got_q.size(), 2);

      // Back-to-back reads at full rate.
      got_q.delete(); ready_drops = 0;
      for (int w = 0; w < 8; w++) send(0, BASE + 32'(w * 4), 4'b0, 32'h0, sa, sm, scsb);
      wait_idle();
      chk("t3_ready_drops", ready_drops, 0);
      chk("t3_nrsp", got_q.size(), 8);
      if (got_q.size() == 8) chk("t3_rsp_span", got_q[7].cyc - got_q[0].cyc, 7);

      // Same burst under 5 cycles of response backpressure.
      got_q.delete(); acc_q.delete(); ready_drops = 0;
      i_rsp_ready = 1'b0;
      c0 = cyc;
      fork
         for (int w = 0; w < 8; w++) send(0, BASE + 32'(w * 4), 4'b0, 32'h0, sa, sm, scsb);
         begin repeat (5) @(posedge i_clk); #1 i_rsp_ready = 1'b1; end
      join
      wait_idle();
      nacc = 0;
      foreach (acc_q[k]) if (acc_q[k] >= c0 && acc_q[k] <= c0 + 4) nacc++;
      chk("t4_accepts_stalled", nacc, 3);
      chk("t4_ready_dropped", ready_drops > 0, 1);
      chk("t4_nrsp", got_q.size(), 8);

      // Out-of-window read between two in-window reads.
      got_q.delete();
      send(0, 32'h1000_0008, 4'b0, 32'h0, sa, sm, scsb);
      send(0, 32'h2000_0000, 4'b0, 32'h0, sa, sm, scsb);
      chk("t5_oow_csb", scsb, 1);
      send(0, 32'h1000_000C, 4'b0, 32'h0, sa, sm, scsb);
      wait_idle();
      if (got_q.size() == 3) begin
         chk("t5_first_err", got_q[0].err, 0);
         chk("t5_oow_err", got_q[1].err, 1);
         chk("t5_oow_rdata", got_q[1].rdata, 0);
         chk("t5_last_err", got_q[2].err, 0);
      end else chk("t5_nrsp", got_q.size(), 3);

      // Reset with two responses buffered.
      i_rsp_ready = 1'b0;
      send(0, BASE, 4'b0, 32'h0, sa, sm, scsb);
      send(0, BASE + 32'd4, 4'b0, 32'h0, sa, sm, scsb);
      @(posedge i_clk); #1;
      chk("t6_pre_busy", o_busy, 1);
      chk("t6_pre_valid", o_rsp_valid, 1);
      i_reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", o_rsp_valid, 0);
      chk("t6_rst_busy", o_busy, 0);
      chk("t6_rst_csb", o_sram_csb, 1);
      repeat (2) @(posedge i_clk);
      #1 i_reset_n = 1'b1; i_rsp_ready = 1'b1;
      got_q.delete();
      send(0, 32'h1000_0004, 4'b0, 32'h0, sa, sm, scsb);
      wait_idle();
      if (got_q.size() == 1) chk("t6_fresh_read", got_q[0].rdata, 32'hDEAA_BEEF);
      else chk("t6_nrsp", got_q.size(), 1);

      // Randomized traffic with random backpressure.
      for (int it = 0; it < 1500; it++) begin
         i_req_valid = ($urandom % 4) != 0;
         i_req_we    = $urandom % 2;
         if (($urandom % 10) == 0) i_req_addr = $urandom;
         else i_req_addr = BASE + 32'(($urandom % 32) * 4) + 32'($urandom % 4);
         i_req_be    = 4'($urandom);
         i_req_wdata = $urandom;
         i_rsp_ready = ($urandom % 4) != 0;
         @(posedge i_clk); #1;
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      wait_idle();
      chk("rand_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
